// File: rtl/cell_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_arb_pkg
//  Description : Shared types and helpers for the cell RAM arbiter.
//                req_id_t names the three requesters (bit index into req/gnt),
//                rd_tag_t is one entry of the read-return tag pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package cell_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_VGA = 2'd0,
    REQ_ENG = 2'd1,
    REQ_CPU = 2'd2
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_arb_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cell_arb_rd_pipe
//  Description : RD_LAT-deep shift register of read tags. A tag entering on
//                in_tag appears on out_tag exactly RD_LAT cycles later, in
//                step with the RAM read data it belongs to.
//  Ports       : clk     - clock
//                rst     - asynchronous active-high clear of all stages
//                in_tag  - tag pushed this cycle (valid=0 for no read)
//                out_tag - tag leaving the pipeline this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module cell_arb_rd_pipe
  import cell_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_tag = stage_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/cell_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cell_ram_arbiter
//  Description : Arbitrates the single-port Game-of-Life cell RAM between
//                VGA scanout (fixed priority, starvation-guarded), the life
//                engine and the CPU bridge (round-robin between those two).
//                The command is issued combinationally in the grant cycle;
//                read data returns RD_LAT cycles later tagged in rvalid.
//  Ports       : Clk, Reset_h           - clock, async active-high reset
//                req/we/addr/wdata      - per-requester command (bit/slice
//                                         0=VGA, 1=ENG, 2=CPU)
//                gnt, rvalid, rdata     - grant and tagged read return
//                ram_en/we/addr/wdata   - RAM command
//                ram_rdata              - RAM read data
//  Options     : define CELL_ARB_STATS_EN to add stat_clr input and the
//                saturating grant counters stat_gnt_vga/eng/cpu, stat_forced.
//  Revision    : 1.0  initial release
// ============================================================================
module cell_ram_arbiter
  import cell_arb_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic                      Clk,
  input  logic                      Reset_h,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
`ifdef CELL_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [15:0]               stat_gnt_vga,
  output logic [15:0]               stat_gnt_eng,
  output logic [15:0]               stat_gnt_cpu,
  output logic [15:0]               stat_forced
`endif
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  req_id_t          rr_ptr;
  logic [CNT_W-1:0] starve_cnt;

  req_id_t lo_id;
  req_id_t win_id;
  logic    low_pend;
  logic    forced;
  logic    grant_vga;
  logic    grant_low;
  logic    grant_any;

  rd_tag_t push_tag;
  rd_tag_t exit_tag;
  logic [DATA_W-1:0] rdata_hold;

  // --------------------------------------------------------------------------
  // Grant decision and RAM command mux
  // --------------------------------------------------------------------------
  always_comb begin
    low_pend = req[1] | req[2];

    // Round-robin pointer only matters when both low-priority sides ask.
    if (req[1] && req[2]) begin
      lo_id = rr_ptr;
    end else if (req[1]) begin
      lo_id = REQ_ENG;
    end else begin
      lo_id = REQ_CPU;
    end

    forced    = req[0] && low_pend && (starve_cnt == STARVE_LIM);
    // Grants are suppressed while reset is held so no RAM command escapes.
    grant_vga = !Reset_h && req[0] && !forced;
    grant_low = !Reset_h && low_pend && (!req[0] || forced);
    grant_any = grant_vga || grant_low;
    win_id    = grant_vga ? REQ_VGA : lo_id;

    gnt       = '0;
    ram_en    = grant_any;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    if (grant_any) begin
      case (win_id)
        REQ_VGA: begin
          gnt[0]    = 1'b1;
          ram_we    = we[0];
          ram_addr  = addr[0 +: ADDR_W];
          ram_wdata = wdata[0 +: DATA_W];
        end
        REQ_ENG: begin
          gnt[1]    = 1'b1;
          ram_we    = we[1];
          ram_addr  = addr[ADDR_W +: ADDR_W];
          ram_wdata = wdata[DATA_W +: DATA_W];
        end
        default: begin
          gnt[2]    = 1'b1;
          ram_we    = we[2];
          ram_addr  = addr[2*ADDR_W +: ADDR_W];
          ram_wdata = wdata[2*DATA_W +: DATA_W];
        end
      endcase
    end

    push_tag.valid = grant_any && !ram_we;
    push_tag.id    = win_id;
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer and starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      rr_ptr <= REQ_ENG;
    end else if (grant_low) begin
      rr_ptr <= (lo_id == REQ_ENG) ? REQ_CPU : REQ_ENG;
    end
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      starve_cnt <= '0;
    end else if (grant_low || !low_pend) begin
      starve_cnt <= '0;
    end else if (grant_vga && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Read return: the tag leaves the pipe in the cycle the RAM presents the
  // data, so rdata bypasses ram_rdata then and holds the captured value after.
  // --------------------------------------------------------------------------
  cell_arb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (Clk),
    .rst     (Reset_h),
    .in_tag  (push_tag),
    .out_tag (exit_tag)
  );

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      rdata_hold <= '0;
    end else if (exit_tag.valid) begin
      rdata_hold <= ram_rdata;
    end
  end

  always_comb begin
    rvalid = '0;
    if (exit_tag.valid) begin
      rvalid = NUM_REQ'(1) << exit_tag.id;
    end
    rdata = exit_tag.valid ? ram_rdata : rdata_hold;
  end

`ifdef CELL_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating grant statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      stat_gnt_vga <= '0;
      stat_gnt_eng <= '0;
      stat_gnt_cpu <= '0;
      stat_forced  <= '0;
    end else if (stat_clr) begin
      stat_gnt_vga <= '0;
      stat_gnt_eng <= '0;
      stat_gnt_cpu <= '0;
      stat_forced  <= '0;
    end else begin
      if (gnt[0]) stat_gnt_vga <= sat_inc16(stat_gnt_vga);
      if (gnt[1]) stat_gnt_eng <= sat_inc16(stat_gnt_eng);
      if (gnt[2]) stat_gnt_cpu <= sat_inc16(stat_gnt_cpu);
      if (forced && grant_low) stat_forced <= sat_inc16(stat_forced);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cell_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_ram_arbiter
//  Description : Self-checking bench for cell_ram_arbiter with a write-first
//                RAM model of read latency 2. Table of per-cycle vectors plus
//                hand sequences for write/read-back, starvation and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cell_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          Clk;
  logic          Reset_h;
  logic [2:0]    req;
  logic [2:0]    we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef CELL_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_gnt_vga, stat_gnt_eng, stat_gnt_cpu, stat_forced;
`endif

  cell_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(15)
  ) dut (
    .Clk       (Clk),
    .Reset_h   (Reset_h),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef CELL_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_gnt_vga (stat_gnt_vga),
    .stat_gnt_eng (stat_gnt_eng),
    .stat_gnt_cpu (stat_gnt_cpu),
    .stat_forced  (stat_forced)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Write-first RAM model, two-cycle read latency.
  logic [DW-1:0] mem [8192];
  logic [DW-1:0] rd_p0, rd_p1;
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 ^ 32'(i);
    rd_p0 = '0;
    rd_p1 = '0;
  end
  always @(posedge Clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_p0 <= ram_we ? ram_wdata : mem[ram_addr];
    end else begin
      rd_p0 <= '0;
    end
    rd_p1 <= rd_p0;
  end
  assign ram_rdata = rd_p1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  // Default per-requester addresses: VGA=0x0001, ENG=0x0002, CPU=0x0040.
  localparam logic [3*AW-1:0] ADDR_DEF = {13'h0040, 13'h0002, 13'h0001};

  function automatic logic [AW-1:0] addr_of(input logic [2:0] g);
    case (g)
      3'b001:  return 13'h0001;
      3'b010:  return 13'h0002;
      3'b100:  return 13'h0040;
      default: return 13'h0000;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #1 Reset_h = 1'b1;
    req = '0; we = '0;
    repeat (2) @(posedge Clk);
    #1 Reset_h = 1'b0;
  endtask

  initial begin
    logic [31:0] last_rdata;
    logic [2:0]  exp_g;

    tbl[0]  = '{3'b100, 3'b100, 3'b000, 32'h0};
    tbl[1]  = '{3'b000, 3'b000, 3'b000, 32'h0};
    tbl[2]  = '{3'b000, 3'b000, 3'b100, 32'hC0DE0040};
    tbl[3]  = '{3'b110, 3'b010, 3'b000, 32'h0};
    tbl[4]  = '{3'b110, 3'b100, 3'b000, 32'h0};
    tbl[5]  = '{3'b110, 3'b010, 3'b010, 32'hC0DE0002};
    tbl[6]  = '{3'b110, 3'b100, 3'b100, 32'hC0DE0040};
    tbl[7]  = '{3'b001, 3'b001, 3'b010, 32'hC0DE0002};
    tbl[8]  = '{3'b010, 3'b010, 3'b100, 32'hC0DE0040};
    tbl[9]  = '{3'b001, 3'b001, 3'b001, 32'hC0DE0001};
    tbl[10] = '{3'b000, 3'b000, 3'b010, 32'hC0DE0002};
    tbl[11] = '{3'b000, 3'b000, 3'b001, 32'hC0DE0001};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 32'h0};
    tbl[13] = '{3'b011, 3'b001, 3'b000, 32'h0};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 32'h0};
    tbl[15] = '{3'b000, 3'b000, 3'b001, 32'hC0DE0001};
    tbl[16] = '{3'b010, 3'b010, 3'b000, 32'h0};
    tbl[17] = '{3'b000, 3'b000, 3'b000, 32'h0};
    tbl[18] = '{3'b000, 3'b000, 3'b010, 32'hC0DE0002};

    Reset_h = 1'b1;
    req = '0; we = '0; addr = ADDR_DEF; wdata = '0;
`ifdef CELL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1 Reset_h = 1'b0;

    // ---- reset state ----
    @(negedge Clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    next_cycle();

    // ---- table-driven vectors (sequential from reset) ----
    last_rdata = 32'h0;
    for (int i = 0; i < NV; i++) begin
      req = tbl[i].req;
      we  = '0;
      @(negedge Clk);
      if (tbl[i].rvalid != 3'b000) last_rdata = tbl[i].rdata;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(|tbl[i].gnt));
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(addr_of(tbl[i].gnt)));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rvalid));
      chk($sformatf("vec%0d_rdata", i), rdata, last_rdata);
      next_cycle();
    end

    // ---- ENG write, then CPU read-back of the same address ----
    addr[AW +: AW]  = 13'h0100;
    wdata[DW +: DW] = 32'hDEADBEEF;
    req = 3'b010; we = 3'b010;
    @(negedge Clk);
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_ram_we", 32'(ram_we), 32'h1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h100);
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    next_cycle();
    addr[2*AW +: AW] = 13'h0100;
    req = 3'b100; we = 3'b000;
    @(negedge Clk);
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_ram_we", 32'(ram_we), 32'h0);
    chk("rd_ram_addr", 32'(ram_addr), 32'h100);
    next_cycle();
    req = 3'b000;
    @(negedge Clk);
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    next_cycle();
    @(negedge Clk);
    chk("raw_rvalid", 32'(rvalid), 32'h4);
    chk("raw_rdata", rdata, 32'hDEADBEEF);
    next_cycle();
    addr = ADDR_DEF; wdata = '0;

    // ---- starvation guard: all three requesting continuously ----
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 64; k++) begin
      if ((k % 16) < 15)      exp_g = 3'b001;
      else if (((k / 16) % 2) == 0) exp_g = 3'b010;
      else                    exp_g = 3'b100;
      @(negedge Clk);
      chk($sformatf("starve%0d_gnt", k), 32'(gnt), 32'(exp_g));
      next_cycle();
    end
    req = 3'b000;
`ifdef CELL_ARB_STATS_EN
    @(negedge Clk);
    chk("stat_forced", 32'(stat_forced), 32'd4);
    chk("stat_gnt_vga", 32'(stat_gnt_vga), 32'd60);
    chk("stat_gnt_eng", 32'(stat_gnt_eng), 32'd2);
    chk("stat_gnt_cpu", 32'(stat_gnt_cpu), 32'd2);
    next_cycle();
`endif
    repeat (3) next_cycle();

    // ---- reset one cycle after a VGA read grant ----
    req = 3'b001;
    @(negedge Clk);
    chk("mr_vga_gnt", 32'(gnt), 32'h1);
    next_cycle();
    Reset_h = 1'b1;
    req = 3'b000;
    @(negedge Clk);
    chk("mr_in_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mr_in_rst_gnt", 32'(gnt), 32'h0);
    #2 Reset_h = 1'b0;
    next_cycle();
    // In-flight VGA read would have returned in this cycle.
    req = 3'b111;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      if (k == 0) chk("mr_flushed_rvalid", 32'(rvalid), 32'h0);
      chk($sformatf("mr%0d_gnt", k), 32'(gnt), (k < 15) ? 32'h1 : 32'h2);
      next_cycle();
    end
    req = 3'b000;
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
